// File: rtl/dreg_pkg.sv
// Shared types for the dreg_bank sample-and-hold slice: capture modes,
// per-channel state encoding and a small edge-detect helper.
package dreg_pkg;

  // Global capture mode, encoded as on the mode input bus
  typedef enum logic [1:0] {
    MODE_TRACK = 2'd0,
    MODE_EDGE  = 2'd1,
    MODE_LOCK  = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  // Per-channel state: free to capture, or frozen by a timed lock
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  // Rising edge of a level given its current and previous-cycle value
  function automatic logic rising_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/dreg_channel.sv
// One sample-and-hold channel: WIDTH-bit holding register with track,
// edge-capture and timed-lock capture modes, a valid flag and a
// saturating capture counter.
module dreg_channel
  import dreg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LOCK_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_e            mode,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             locked,
  output logic [CNT_W-1:0] upd_cnt
);

  localparam int              LCW       = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0]  LOCK_LOAD = LCW'(LOCK_CYCLES);
  localparam logic [LCW-1:0]  LOCK_LAST = LCW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             en_d_r;
  state_e           state_r;
  logic [LCW-1:0]   lock_cnt_r;
  logic [WIDTH-1:0] q_r;
  logic             valid_r;
  logic [CNT_W-1:0] upd_cnt_r;

  logic             rise_s;
  logic             capture_s;
  logic             start_lock_s;

  // Capture decision: only an idle channel may capture; the mode picks level or edge
  always_comb begin
    rise_s       = rising_edge(en, en_d_r);
    capture_s    = 1'b0;
    start_lock_s = 1'b0;
    if (state_r == ST_IDLE) begin
      case (mode)
        MODE_TRACK: capture_s = en;
        MODE_EDGE:  capture_s = rise_s;
        MODE_LOCK: begin
          capture_s    = rise_s;
          start_lock_s = rise_s;
        end
        MODE_HOLD:  capture_s = 1'b0;
        default:    capture_s = 1'b0;
      endcase
    end else begin
      capture_s    = 1'b0;
      start_lock_s = 1'b0;
    end
  end

  // Previous-cycle enable; keeps sampling through clr and lock so edges stay honest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d_r <= 1'b0;
    end else begin
      en_d_r <= en;
    end
  end

  // Lock sequencer: load on a LOCK-mode capture, count down, release after the last cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      lock_cnt_r <= '0;
    end else if (clr) begin
      state_r    <= ST_IDLE;
      lock_cnt_r <= '0;
    end else if (state_r == ST_LOCK) begin
      if (lock_cnt_r == LOCK_LAST) begin
        state_r    <= ST_IDLE;
        lock_cnt_r <= '0;
      end else begin
        lock_cnt_r <= lock_cnt_r - LOCK_LAST;
      end
    end else if (start_lock_s) begin
      state_r    <= ST_LOCK;
      lock_cnt_r <= LOCK_LOAD;
    end else begin
      state_r    <= state_r;
      lock_cnt_r <= lock_cnt_r;
    end
  end

  // Holding register, valid flag and saturating capture counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r       <= '0;
      valid_r   <= 1'b0;
      upd_cnt_r <= '0;
    end else if (clr) begin
      q_r       <= '0;
      valid_r   <= 1'b0;
      upd_cnt_r <= '0;
    end else if (capture_s) begin
      q_r     <= d;
      valid_r <= 1'b1;
      if (upd_cnt_r != CNT_MAX) begin
        upd_cnt_r <= upd_cnt_r + CNT_W'(1);
      end else begin
        upd_cnt_r <= upd_cnt_r;
      end
    end else begin
      q_r       <= q_r;
      valid_r   <= valid_r;
      upd_cnt_r <= upd_cnt_r;
    end
  end

  assign q       = q_r;
  assign valid   = valid_r;
  assign locked  = (state_r == ST_LOCK);
  assign upd_cnt = upd_cnt_r;

endmodule

// File: rtl/dreg_bank.sv
// Multi-channel clocked sample-and-hold bank. Each channel is an
// independent dreg_channel; this level only fans out the shared mode/clr
// controls and packs the per-channel buses.
module dreg_bank
  import dreg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int LOCK_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       locked,
  output logic [CHANNELS*CNT_W-1:0] upd_cnt
);

  mode_e mode_s;

  assign mode_s = mode_e'(mode);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    dreg_channel #(
      .WIDTH       (WIDTH),
      .LOCK_CYCLES (LOCK_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .mode    (mode_s),
      .clr     (clr),
      .en      (en[i]),
      .d       (d[i*WIDTH +: WIDTH]),
      .q       (q[i*WIDTH +: WIDTH]),
      .valid   (valid[i]),
      .locked  (locked[i]),
      .upd_cnt (upd_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_dreg_bank.sv
// Scoreboard bench for dreg_bank: the stimulus process pushes hand-computed
// per-channel expectations tagged with the cycle they apply to; a monitor
// pops and compares them just after each rising clock edge.
module tb_dreg_bank;
  import dreg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        clr = 1'b0;
  logic [3:0]  en = 4'd0;
  logic [31:0] d = 32'd0;

  logic [31:0] q_a, q_b;
  logic [3:0]  valid_a, valid_b, locked_a, locked_b;
  logic [31:0] cnt_a;
  logic [7:0]  cnt_b;

  int n_cmp = 0;
  int n_bad = 0;
  int step_cyc = 0;
  int mon_cyc = 0;

  typedef struct {
    int    cyc;
    int    dsel;
    int    ch;
    int    q;
    int    v;
    int    l;
    int    cnt;
    string nm;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  dreg_bank #(.WIDTH(8), .CHANNELS(4), .LOCK_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .clr(clr), .en(en), .d(d),
    .q(q_a), .valid(valid_a), .locked(locked_a), .upd_cnt(cnt_a)
  );

  dreg_bank #(.WIDTH(8), .CHANNELS(4), .LOCK_CYCLES(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .clr(clr), .en(en), .d(d),
    .q(q_b), .valid(valid_b), .locked(locked_b), .upd_cnt(cnt_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] m, input logic c, input logic [3:0] e,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3);
    @(negedge clk);
    rst  = 1'b0;
    mode = m;
    clr  = c;
    en   = e;
    d    = {d3, d2, d1, d0};
    step_cyc++;
  endtask

  task automatic exp_push(input int dsel, input int ch, input int eq, input int ev,
                          input int el, input int ec, input string nm);
    exp_t it;
    it.cyc = step_cyc; it.dsel = dsel; it.ch = ch;
    it.q = eq; it.v = ev; it.l = el; it.cnt = ec; it.nm = nm;
    sbq.push_back(it);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".q_a"}, q_a, 32'd0);
    chk({nm, ".valid_a"}, {28'd0, valid_a}, 32'd0);
    chk({nm, ".locked_a"}, {28'd0, locked_a}, 32'd0);
    chk({nm, ".cnt_a"}, cnt_a, 32'd0);
    chk({nm, ".q_b"}, q_b, 32'd0);
    chk({nm, ".cnt_b"}, {24'd0, cnt_b}, 32'd0);
  endtask

  // Monitor: after each edge out of reset, compare every expectation due this cycle
  initial begin
    exp_t it;
    logic [31:0] aq, av, al, ac;
    forever begin
      @(posedge clk);
      if (!rst) begin
        mon_cyc++;
        #1;
        while (sbq.size() > 0 && sbq[0].cyc <= mon_cyc) begin
          it = sbq.pop_front();
          chk({it.nm, ".cycle"}, it.cyc, mon_cyc);
          if (it.dsel == 0) begin
            aq = {24'd0, q_a[it.ch*8 +: 8]};
            av = {31'd0, valid_a[it.ch]};
            al = {31'd0, locked_a[it.ch]};
            ac = {24'd0, cnt_a[it.ch*8 +: 8]};
          end else begin
            aq = {24'd0, q_b[it.ch*8 +: 8]};
            av = {31'd0, valid_b[it.ch]};
            al = {31'd0, locked_b[it.ch]};
            ac = {30'd0, cnt_b[it.ch*2 +: 2]};
          end
          chk({it.nm, ".q"}, aq, it.q);
          chk({it.nm, ".valid"}, av, it.v);
          chk({it.nm, ".locked"}, al, it.l);
          chk({it.nm, ".upd_cnt"}, ac, it.cnt);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    // Asynchronous reset with random inputs, checked before any clock edge
    #1;
    rst  = 1'b1;
    en   = 4'($urandom);
    d    = $urandom;
    mode = 2'($urandom);
    #1;
    chk_all_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 4'($urandom);
      d  = $urandom;
      chk_all_zero("rst_held");
    end

    // Release with en3 already high counts as a rising edge (EDGE mode)
    step(MODE_EDGE, 1'b0, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h77);
    exp_push(0, 3, 'h77, 1, 0, 1, "rel_edge_a");
    exp_push(1, 3, 'h77, 1, 0, 1, "rel_edge_b");
    exp_push(0, 0, 'h00, 0, 0, 0, "rel_ch0_idle");

    // TRACK on ch0
    step(MODE_TRACK, 1'b0, 4'b0001, 8'h11, 8'h00, 8'h00, 8'h00);
    exp_push(0, 0, 'h11, 1, 0, 1, "track1");
    step(MODE_TRACK, 1'b0, 4'b0001, 8'h22, 8'h00, 8'h00, 8'h00);
    exp_push(0, 0, 'h22, 1, 0, 2, "track2");
    step(MODE_TRACK, 1'b0, 4'b0001, 8'h33, 8'h00, 8'h00, 8'h00);
    exp_push(0, 0, 'h33, 1, 0, 3, "track3");
    step(MODE_TRACK, 1'b0, 4'b0000, 8'h44, 8'h00, 8'h00, 8'h00);
    exp_push(0, 0, 'h33, 1, 0, 3, "track_hold");
    exp_push(0, 3, 'h77, 1, 0, 1, "track_ch3_kept");

    // EDGE on ch1: en held high for 5 cycles captures once
    for (int i = 0; i < 5; i++) begin
      step(MODE_EDGE, 1'b0, 4'b0010, 8'h00, 8'(8'hA1 + i), 8'h00, 8'h00);
      exp_push(0, 1, 'hA1, 1, 0, 1, "edge_held");
    end
    step(MODE_EDGE, 1'b0, 4'b0000, 8'h00, 8'hB0, 8'h00, 8'h00);
    exp_push(0, 1, 'hA1, 1, 0, 1, "edge_low");
    step(MODE_EDGE, 1'b0, 4'b0010, 8'h00, 8'hB1, 8'h00, 8'h00);
    exp_push(0, 1, 'hB1, 1, 0, 2, "edge_recap");

    // LOCK on ch2: 4 locked cycles, edges inside and on expiry ignored
    step(MODE_LOCK, 1'b0, 4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00);
    exp_push(0, 2, 'hA5, 1, 1, 1, "lock_cap");
    step(MODE_LOCK, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h5A, 8'h00);
    exp_push(0, 2, 'hA5, 1, 1, 1, "lock_c2");
    step(MODE_LOCK, 1'b0, 4'b0100, 8'h00, 8'h00, 8'h5A, 8'h00);
    exp_push(0, 2, 'hA5, 1, 1, 1, "lock_c3");
    step(MODE_LOCK, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h5A, 8'h00);
    exp_push(0, 2, 'hA5, 1, 1, 1, "lock_c4");
    step(MODE_LOCK, 1'b0, 4'b0100, 8'h00, 8'h00, 8'h5A, 8'h00);
    exp_push(0, 2, 'hA5, 1, 0, 1, "lock_expire_edge");
    step(MODE_LOCK, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h5A, 8'h00);
    exp_push(0, 2, 'hA5, 1, 0, 1, "lock_idle");
    step(MODE_LOCK, 1'b0, 4'b0100, 8'h00, 8'h00, 8'hC3, 8'h00);
    exp_push(0, 2, 'hC3, 1, 1, 2, "lock_recap");

    // Switch to HOLD mid-lock: lock still runs its full length
    step(MODE_HOLD, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h5A, 8'h00);
    exp_push(0, 2, 'hC3, 1, 1, 2, "hold_midlock2");
    step(MODE_HOLD, 1'b0, 4'b0100, 8'h00, 8'h00, 8'h5A, 8'h00);
    exp_push(0, 2, 'hC3, 1, 1, 2, "hold_midlock3");
    step(MODE_HOLD, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h5A, 8'h00);
    exp_push(0, 2, 'hC3, 1, 1, 2, "hold_midlock4");
    step(MODE_HOLD, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h5A, 8'h00);
    exp_push(0, 2, 'hC3, 1, 0, 2, "hold_unlock");
    step(MODE_HOLD, 1'b0, 4'b0100, 8'h00, 8'h00, 8'h5A, 8'h00);
    exp_push(0, 2, 'hC3, 1, 0, 2, "hold_nocap");

    // clr beats a lock and an all-ones TRACK capture
    step(MODE_LOCK, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    exp_push(0, 2, 'hC3, 1, 0, 2, "pre_clr_idle");
    step(MODE_LOCK, 1'b0, 4'b0100, 8'h00, 8'h00, 8'hE7, 8'h00);
    exp_push(0, 2, 'hE7, 1, 1, 3, "lock_before_clr");
    step(MODE_TRACK, 1'b1, 4'b1111, 8'h99, 8'h99, 8'h99, 8'h99);
    for (int c = 0; c < 4; c++) exp_push(0, c, 0, 0, 0, 0, "clr");
    exp_push(1, 0, 0, 0, 0, 0, "clr_b");
    step(MODE_TRACK, 1'b0, 4'b1111, 8'h10, 8'h20, 8'h30, 8'h40);
    exp_push(0, 0, 'h10, 1, 0, 1, "post_clr0");
    exp_push(0, 1, 'h20, 1, 0, 1, "post_clr1");
    exp_push(0, 2, 'h30, 1, 0, 1, "post_clr2");
    exp_push(0, 3, 'h40, 1, 0, 1, "post_clr3");
    exp_push(1, 0, 'h10, 1, 0, 1, "sat1");

    // Saturation of the 2-bit counter while q keeps tracking
    for (int i = 1; i <= 5; i++) begin
      step(MODE_TRACK, 1'b0, 4'b1111, 8'(8'h50 + i), 8'h20, 8'h30, 8'h40);
      exp_push(1, 0, 'h50 + i, 1, 0, (i + 1 > 3) ? 3 : i + 1, "sat");
      exp_push(0, 0, 'h50 + i, 1, 0, i + 1, "nosat");
    end

    // Lock ch2 then assert rst mid-lock
    step(MODE_LOCK, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    exp_push(0, 2, 'h30, 1, 0, 6, "pre_rst_idle");
    step(MODE_LOCK, 1'b0, 4'b0100, 8'h00, 8'h00, 8'hF0, 8'h00);
    exp_push(0, 2, 'hF0, 1, 1, 7, "pre_rst_lock");
    @(posedge clk);
    #3;
    chk("sb_drain", sbq.size(), 32'd0);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_midlock");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dreg_bank.md
# dreg_bank

Parametrised multi-channel D-storage bank. It replaces single-bit latch cells with clocked, per-channel WIDTH-bit holding registers. Each channel has three capture modes: track, edge-capture, and timed lock. It also provides a valid flag, a lock status and a saturating update counter. It sits between data sources and downstream consumers that need gated, auditable sample-and-hold.

## Interface
- WIDTH, 8, data bits per channel
- CHANNELS, 4, number of independent channels
- LOCK_CYCLES, 4, cycles a channel stays locked after a LOCK-mode capture (≥1)
- CNT_W, 8, width of each per-channel update counter
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  2  global capture mode: 0 TRACK, 1 EDGE, 2 LOCK, 3 HOLD
- clr  in  1  synchronous clear of all channels
- en  in  CHANNELS  per-channel enable
- d  in  CHANNELS*WIDTH  channel data, channel i at bits [i*WIDTH +: WIDTH]
- q  out  CHANNELS*WIDTH  held data, same packing as d
- valid  out  CHANNELS  channel holds a captured value since reset/clr
- locked  out  CHANNELS  channel is in LOCK state
- upd_cnt  out  CHANNELS*CNT_W  per-channel capture count, saturating

## Operation
- Per-channel registers: q_i, en_d_i (previous en), state_i ∈ {IDLE, LOCK}, lock counter, upd_cnt_i, valid_i.
- A capture loads q_i ← d_i, sets valid_i and increments upd_cnt_i. The counter stops at 2^CNT_W−1.
- Rising edge of en is defined as en_i=1 and en_d_i=0. en_d_i updates every cycle, including while locked.
- Capture condition, channel in IDLE:
  - TRACK: en_i=1 on any cycle, which gives latch-like transparency with registered output.
  - EDGE: rising edge of en only.
  - LOCK: rising edge of en only. It also moves the channel to LOCK and loads the lock counter with LOCK_CYCLES.
  - HOLD: never.
- LOCK state:
  - No captures regardless of en and mode.
  - Counter decrements each cycle; at 1 → IDLE next cycle.
  - locked_i=1 for exactly LOCK_CYCLES cycles.
- A mode change while a channel is locked does not abort the lock. The new mode applies once the channel is IDLE.
- clr has priority over everything. It sets q, valid, upd_cnt and locked to 0 and all channels to IDLE in one cycle. en_d still samples en.
- Channels are independent. Simultaneous captures on all channels are allowed.

## Timing
- rst asserted: all outputs and internal state are 0 immediately (asynchronous), states are IDLE, and en_d=0.
- Reset release with en_i already 1 counts as a rising edge on the first clock.
- Capture latency is 1 cycle: d sampled at edge N appears on q, valid and upd_cnt after edge N.
- locked rises after the capturing edge, together with q.
- A new rising edge on the cycle the lock expires (counter=1) is ignored. The earliest recapture is on the edge after locked falls.
- rst mid-lock aborts the lock immediately.

## Structure
- Shared package dreg_pkg:
  - mode enum: MODE_TRACK=0, MODE_EDGE=1, MODE_LOCK=2, MODE_HOLD=3.
  - channel state enum: ST_IDLE, ST_LOCK.
- Sub-module dreg_channel: one channel with WIDTH, LOCK_CYCLES and CNT_W parameters. dreg_bank instantiates CHANNELS copies in a generate loop and handles the bus packing.
- Lock counter width is $clog2(LOCK_CYCLES+1).

## Test plan
- Reset: assert rst with random d/en. q, valid, locked and upd_cnt are all 0 with no clock edge, and remain so until rst drops.
- TRACK, ch0: en=1 with d=0x11, 0x22, 0x33 on consecutive cycles. q0 follows with 1-cycle lag and upd_cnt0=3. Then en=0 with d=0x44: q0 stays 0x33.
- EDGE, ch1: hold en1=1 for 5 cycles while d changes. q1 takes only the first-cycle value and upd_cnt1=1. Drop and raise en1: second capture, upd_cnt1=2.
- LOCK, ch2, LOCK_CYCLES=4:
  - Rising edge with d=0xA5: q2=0xA5 and locked2=1 for 4 cycles.
  - Toggle en2 with d=0x5A during the lock and on its final cycle: q2 stays 0xA5.
  - Next rising edge after unlock: captures.
  - Switch mode to HOLD mid-lock: the lock still lasts 4 cycles.
- clr vs capture: in TRACK, assert clr with en=all-ones. q, valid and upd_cnt are all 0 next cycle. Captures resume the cycle after clr drops.
- Saturation: CNT_W=2 in TRACK with en held for 6 cycles gives upd_cnt=3, with q still updating every cycle.
